// File: rtl/fifo_narrow_wide.sv
// Narrow-to-wide packing FIFO: DINWIDTH slices packed MSB-first into DOUTWIDTH words, FWFT read side.
// Latency: word visible on dout the edge after its last slice is written; full blocks writes, empty blocks pops.
module fifo_narrow_wide #(
  parameter int DINWIDTH  = 16,
  parameter int DOUTWIDTH = 64,
  parameter int DEPTH     = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wr_en,
  input  logic                 rd_en,
  input  logic [DINWIDTH-1:0]  din,
  output logic [DOUTWIDTH-1:0] dout,
  output logic                 full,
  output logic                 empty,
  output logic                 partial
);

  localparam int RATIO = DOUTWIDTH / DINWIDTH;
  localparam int PW    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = AW + 1;
  localparam logic [PW-1:0] PACK_LAST = PW'(RATIO - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);

  if ((DOUTWIDTH % DINWIDTH) != 0 || RATIO < 2 || (RATIO & (RATIO - 1)) != 0) begin : g_bad_ratio
    $error("fifo_narrow_wide: DOUTWIDTH/DINWIDTH must be an integer power of two >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_narrow_wide: DEPTH must be a power of two >= 2");
  end

  logic [DOUTWIDTH-1:0] r_mem [DEPTH];
  logic [DOUTWIDTH-1:0] r_pack;
  logic [PW-1:0]        r_pack_cnt;
  logic [AW-1:0]        r_wr_ptr;
  logic [AW-1:0]        r_rd_ptr;
  logic [CW-1:0]        r_cnt;
  logic [DOUTWIDTH-1:0] r_dout;
  logic                 r_full;
  logic                 r_empty;
  logic                 r_partial;

  logic                 w_wr_acc;
  logic                 w_rd_acc;
  logic                 w_push;
  logic                 w_bypass;
  logic [DOUTWIDTH-1:0] w_pack_word;
  logic [PW-1:0]        w_pack_cnt_nxt;
  logic [AW-1:0]        w_rd_ptr_nxt;
  logic [CW-1:0]        w_cnt_nxt;
  logic [DOUTWIDTH-1:0] w_dout_nxt;

  always_comb begin
    w_wr_acc       = wr_en && !r_full;
    w_rd_acc       = rd_en && !r_empty;
    w_push         = w_wr_acc && (r_pack_cnt == PACK_LAST);
    // Shifting in at the LSB leaves the first slice of a group in the MSB position.
    w_pack_word    = {r_pack[DOUTWIDTH-DINWIDTH-1:0], din};
    w_pack_cnt_nxt = w_wr_acc ? r_pack_cnt + PW'(1) : r_pack_cnt;
    w_rd_ptr_nxt   = r_rd_ptr + AW'(w_rd_acc);
    w_cnt_nxt      = r_cnt + CW'(w_push) - CW'(w_rd_acc);
    // A word pushed into an otherwise-empty store is not in r_mem yet, so forward it.
    w_bypass       = w_push && ((r_cnt - CW'(w_rd_acc)) == '0);
    w_dout_nxt     = r_dout;
    if (w_bypass) begin
      w_dout_nxt = w_pack_word;
    end else if (w_cnt_nxt != '0) begin
      w_dout_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_pack     <= '0;
      r_pack_cnt <= '0;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_cnt      <= '0;
      r_dout     <= '0;
      r_full     <= 1'b0;
      r_empty    <= 1'b1;
      r_partial  <= 1'b0;
    end else begin
      if (w_wr_acc) begin
        r_pack <= w_pack_word;
      end
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_pack_word;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_pack_cnt <= w_pack_cnt_nxt;
      r_rd_ptr   <= w_rd_ptr_nxt;
      r_cnt      <= w_cnt_nxt;
      r_dout     <= w_dout_nxt;
      r_full     <= (w_cnt_nxt == CNT_FULL) && (w_pack_cnt_nxt == PACK_LAST);
      r_empty    <= (w_cnt_nxt == '0);
      r_partial  <= (w_pack_cnt_nxt != '0);
    end
  end

  assign dout    = r_dout;
  assign full    = r_full;
  assign empty   = r_empty;
  assign partial = r_partial;

endmodule
